// File: rtl/fft_seq_pkg.sv
// -----------------------------------------------------------------------------
// fft_seq_pkg
//   Shared definitions for the FFT frame sequencer:
//     seq_state_e  - sequencer states FILL / COMPUTE / DRAIN
//     MAX_IDX_W    - widest bin index bit_reverse() can handle
//     bit_reverse  - reverses the low 'bits' bits of an index. Used when
//                    bins leave in bit-reversed order (FFT_SEQ_BITREV_OUT_EN).
// -----------------------------------------------------------------------------
package fft_seq_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } seq_state_e;

    localparam int MAX_IDX_W = 16;

    // Shifting value[0] in first leaves it at bit (bits-1) after 'bits'
    // iterations, which is exactly the bit-reversed index.
    function automatic logic [MAX_IDX_W-1:0] bit_reverse(
        input logic [MAX_IDX_W-1:0] value,
        input int                   bits
    );
        logic [MAX_IDX_W-1:0] result;
        result = '0;
        for (int b = 0; b < MAX_IDX_W; b++) begin
            if (b < bits) begin
                result = {result[MAX_IDX_W-2:0], value[b]};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_seq_result_buf.sv
// -----------------------------------------------------------------------------
// fft_seq_result_buf
//   Holds one frame of FFT bins. The whole frame is captured in a single cycle
//   and read back one bin at a time.
//   Ports:
//     clk, rst         - clock, asynchronous active-high reset (clears buffer)
//     capture_en_i     - load capture_data_i into the buffer on this edge
//     capture_data_i   - all SAMPLES bins from the datapath
//     rd_idx_i         - bin index to read
//     rd_data_o        - bin at rd_idx_i
// -----------------------------------------------------------------------------
module fft_seq_result_buf
    import fft_seq_pkg::*;
#(
    parameter  int SAMPLES = 16,
    parameter  int WIDTH   = 32,
    localparam int IDX_W   = $clog2(SAMPLES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           capture_en_i,
    input  logic [SAMPLES-1:0][WIDTH-1:0]  capture_data_i,
    input  logic [IDX_W-1:0]               rd_idx_i,
    output logic [WIDTH-1:0]               rd_data_o
);

    logic [SAMPLES-1:0][WIDTH-1:0] result_buf_q;

    // NOTE: this storage is reset on purpose: after reset the bin output must
    // read as zero and no bins from an aborted frame may survive, so it is
    // built from flops rather than an unreset RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_buf_q <= '0;
        end else if (capture_en_i) begin
            result_buf_q <= capture_data_i;
        end
    end

    assign rd_data_o = result_buf_q[rd_idx_i];

endmodule

// File: rtl/fft_frame_sequencer.sv
// -----------------------------------------------------------------------------
// fft_frame_sequencer
//   Collects SAMPLES time-domain samples, launches an external FFT datapath,
//   waits COMPUTE_CYCLES for its result, captures all bins and streams them
//   out one per handshake.
//   Ports:
//     clk, rst                 - clock, asynchronous active-high reset
//     in_data/in_valid/in_ready- sample input stream (accepted only in FILL)
//     fft_samples              - current frame, driven to the datapath
//     fft_start                - one-cycle launch pulse (first COMPUTE cycle)
//     fft_result               - bins returned by the datapath
//     out_data/out_index/out_last/out_valid/out_ready
//                              - bin output stream (presented only in DRAIN)
//     busy                     - high whenever the sequencer is not in FILL
//   Build option:
//     FFT_SEQ_BITREV_OUT_EN    - when defined, bins leave in bit-reversed
//                                index order instead of natural order.
// -----------------------------------------------------------------------------
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter  int SAMPLES        = 16,
    parameter  int WIDTH          = 32,
    parameter  int COMPUTE_CYCLES = 1,
    localparam int IDX_W          = $clog2(SAMPLES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [SAMPLES-1:0][WIDTH-1:0] fft_samples,
    output logic                          fft_start,
    input  logic [SAMPLES-1:0][WIDTH-1:0] fft_result,
    output logic [WIDTH-1:0]              out_data,
    output logic [IDX_W-1:0]              out_index,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int               CNT_W    = $clog2(COMPUTE_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COMPUTE_CYCLES);

    seq_state_e                    state_q;
    logic [IDX_W-1:0]              wr_idx_q;
    logic [IDX_W-1:0]              rd_idx_q;
    logic [CNT_W-1:0]              wait_cnt_q;
    logic [SAMPLES-1:0][WIDTH-1:0] sample_buf_q;
    logic                          fft_start_q;

    logic                          capture_en;
    logic [IDX_W-1:0]              order_idx;
    logic [WIDTH-1:0]              bin_data;

    // The launch cycle (fft_start high) only starts the datapath; the
    // COMPUTE_CYCLES countdown runs from the cycle after it, so the result is
    // sampled COMPUTE_CYCLES edges after the datapath saw fft_start.
    assign capture_en = (state_q == COMPUTE) && !fft_start_q
                        && (wait_cnt_q == CNT_W'(1));

    // NOTE: every register in this block uses non-blocking assignment so all
    // of them update together from the pre-edge values, like real flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            wait_cnt_q   <= '0;
            sample_buf_q <= '0;
            fft_start_q  <= 1'b0;
        end else begin
            fft_start_q <= 1'b0;
            case (state_q)
                FILL: begin
                    // in_ready is 1 throughout FILL, so in_valid is the beat.
                    if (in_valid) begin
                        sample_buf_q[wr_idx_q] <= in_data;
                        if (wr_idx_q == LAST_IDX) begin
                            wr_idx_q    <= '0;
                            wait_cnt_q  <= CNT_LOAD;
                            fft_start_q <= 1'b1;
                            state_q     <= COMPUTE;
                        end else begin
                            wr_idx_q <= wr_idx_q + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (!fft_start_q) begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                    if (capture_en) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // out_valid is 1 throughout DRAIN, so out_ready is the beat.
                    if (out_ready) begin
                        if (rd_idx_q == LAST_IDX) begin
                            rd_idx_q <= '0;
                            state_q  <= FILL;
                        end else begin
                            rd_idx_q <= rd_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

`ifdef FFT_SEQ_BITREV_OUT_EN
    assign order_idx = IDX_W'(bit_reverse(MAX_IDX_W'(rd_idx_q), IDX_W));
`else
    assign order_idx = rd_idx_q;
`endif

    fft_seq_result_buf #(
        .SAMPLES (SAMPLES),
        .WIDTH   (WIDTH)
    ) u_result_buf (
        .clk            (clk),
        .rst            (rst),
        .capture_en_i   (capture_en),
        .capture_data_i (fft_result),
        .rd_idx_i       (order_idx),
        .rd_data_o      (bin_data)
    );

    assign in_ready    = (state_q == FILL);
    assign out_valid   = (state_q == DRAIN);
    assign busy        = (state_q != FILL);
    assign fft_start   = fft_start_q;
    assign fft_samples = sample_buf_q;
    assign out_index   = order_idx;
    assign out_data    = bin_data;
    assign out_last    = out_valid && (rd_idx_q == LAST_IDX);

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_sequencer
//   Directed sequence with random sample values for fft_frame_sequencer.
//   The datapath stub returns the frame unchanged, but only once
//   COMPUTE_CYCLES edges have passed since fft_start; before that it returns
//   a poison pattern. Expected bins come from the frame array and the index
//   order rule (natural, or bit-reversed with FFT_SEQ_BITREV_OUT_EN).
// -----------------------------------------------------------------------------
module tb_fft_frame_sequencer;

    localparam int SAMPLES        = 16;
    localparam int WIDTH          = 32;
    localparam int COMPUTE_CYCLES = 4;
    localparam int IDX_W          = $clog2(SAMPLES);
    localparam int FW             = SAMPLES * WIDTH;

    typedef logic [WIDTH-1:0] frame_t [SAMPLES];

    logic                          clk = 1'b0;
    logic                          rst = 1'b0;
    logic [WIDTH-1:0]              in_data = '0;
    logic                          in_valid = 1'b0;
    logic                          in_ready;
    logic [SAMPLES-1:0][WIDTH-1:0] fft_samples;
    logic                          fft_start;
    logic [SAMPLES-1:0][WIDTH-1:0] fft_result;
    logic [WIDTH-1:0]              out_data;
    logic [IDX_W-1:0]              out_index;
    logic                          out_last;
    logic                          out_valid;
    logic                          out_ready = 1'b0;
    logic                          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int age   = 0;

    fft_frame_sequencer #(
        .SAMPLES        (SAMPLES),
        .WIDTH          (WIDTH),
        .COMPUTE_CYCLES (COMPUTE_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .fft_samples (fft_samples),
        .fft_start   (fft_start),
        .fft_result  (fft_result),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stub: result is valid only after COMPUTE_CYCLES edges from the
    // edge that saw fft_start.
    always @(posedge clk or posedge rst) begin
        if (rst)                          age <= 0;
        else if (fft_start)               age <= 1;
        else if (age != 0 && age < 1000)  age <= age + 1;
    end

    assign fft_result = (age >= COMPUTE_CYCLES) ? fft_samples
                                                : {SAMPLES{32'hBAD0_BAD0}};

    function automatic int order(input int i);
`ifdef FFT_SEQ_BITREV_OUT_EN
        int rev = 0;
        int v   = i;
        for (int b = 0; b < IDX_W; b++) begin
            rev = rev * 2 + v % 2;
            v   = v / 2;
        end
        return rev;
`else
        return i;
`endif
    endfunction

    function automatic logic [FW-1:0] pack(input frame_t f);
        logic [FW-1:0] p = '0;
        for (int i = 0; i < SAMPLES; i++) p[i*WIDTH +: WIDTH] = f[i];
        return p;
    endfunction

    task automatic check(input string tag, input logic [FW-1:0] obs,
                         input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at 1 time unit after an edge; returns the same way.
    task automatic send_samples(input frame_t f, input int n, output int t_last);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = f[i];
            check("in_ready_fill", in_ready, 1);
            @(posedge clk); #1;
        end
        t_last   = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_launch(input int t_last);
        int n = 0;
        check("fft_start_on", fft_start, 1);
        check("busy_compute", busy, 1);
        check("in_ready_compute", in_ready, 0);
        @(posedge clk); #1;
        check("fft_start_off", fft_start, 0);
        while (out_valid !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_latency", cyc, t_last + COMPUTE_CYCLES + 1);
        check("out_valid_rise", out_valid, 1);
    endtask

    // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0,1 repeating.
    task automatic drain(input frame_t f, input int mode, input int nbeats);
        int               k = 0;
        int               step = 0;
        bit               stalled = 1'b0;
        bit               rdy;
        logic [WIDTH-1:0] pd = '0;
        logic [IDX_W-1:0] pi = '0;
        logic             pl = 1'b0;
        while (k < nbeats && step < 400) begin
            if (stalled) begin
                check("stall_data", out_data, pd);
                check("stall_index", out_index, pi);
                check("stall_last", out_last, pl);
            end
            rdy       = (mode == 0) || (step % 4 == 0) || (step % 4 == 3);
            out_ready = rdy;
            check("out_valid_drain", out_valid, 1);
            check("in_ready_drain", in_ready, 0);
            if (rdy) begin
                check("bin_index", out_index, order(k));
                check("bin_data", out_data, f[order(k)]);
                check("bin_last", out_last, k == SAMPLES - 1);
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                pd = out_data;
                pi = out_index;
                pl = out_last;
            end
            @(posedge clk); #1;
            step++;
        end
        out_ready = 1'b0;
        check("drain_beats", k, nbeats);
    endtask

    task automatic after_drain();
        check("idle_out_valid", out_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_out_last", out_last, 0);
    endtask

    // Asserts reset between clock edges and checks the cleared outputs
    // before any edge arrives.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_fft_start", fft_start, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_fft_samples", fft_samples, 0);
        @(posedge clk); #4 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_busy", busy, 0);
    endtask

    initial begin
        frame_t fa, fb, fc, fd, fe, ff, fg;
        int     t;

        do_reset();

        // Frame A: 0,100,...,1500 with out_ready held high.
        for (int i = 0; i < SAMPLES; i++) fa[i] = WIDTH'(100 * i);
        send_samples(fa, SAMPLES, t);
        wait_launch(t);
        check("frame_a_samples", fft_samples, pack(fa));
        drain(fa, 0, SAMPLES);
        after_drain();

        // Frame B: random, stalled output, in_valid held high with frame C's
        // first sample through COMPUTE and DRAIN.
        for (int i = 0; i < SAMPLES; i++) begin
            fb[i] = $urandom;
            fc[i] = $urandom;
        end
        send_samples(fb, SAMPLES, t);
        in_valid = 1'b1;
        in_data  = fc[0];
        wait_launch(t);
        drain(fb, 1, SAMPLES);
        check("frame_b_held", fft_samples, pack(fb));
        after_drain();

        // Frame C starts on the cycle right after B's last handshake.
        send_samples(fc, SAMPLES, t);
        wait_launch(t);
        check("frame_c_samples", fft_samples, pack(fc));
        drain(fc, 0, SAMPLES);
        after_drain();

        // Reset after 7 samples of D, then a fresh frame E.
        for (int i = 0; i < SAMPLES; i++) begin
            fd[i] = $urandom;
            fe[i] = $urandom;
        end
        send_samples(fd, 7, t);
        check("partial_busy", busy, 0);
        do_reset();
        send_samples(fe, SAMPLES, t);
        wait_launch(t);
        check("frame_e_samples", fft_samples, pack(fe));
        drain(fe, 0, SAMPLES);
        after_drain();

        // Reset in the middle of draining F, then frame G with stalls.
        for (int i = 0; i < SAMPLES; i++) begin
            ff[i] = $urandom;
            fg[i] = $urandom;
        end
        send_samples(ff, SAMPLES, t);
        wait_launch(t);
        drain(ff, 0, 3);
        check("mid_drain_busy", busy, 1);
        do_reset();
        send_samples(fg, SAMPLES, t);
        wait_launch(t);
        drain(fg, 1, SAMPLES);
        after_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 SHALL have parameter SAMPLES, default 16: points per frame, a power of two, at least 2.
REQ-002 SHALL have parameter WIDTH, default 32: bits per sample and per bin.
REQ-003 SHALL have parameter COMPUTE_CYCLES, default 1: cycles from fft_start to a stable fft_result, at least 1.
REQ-004 SHALL have clk, input, 1: the single clock, with all state on its rising edge.
REQ-005 SHALL have rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have in_data, input, WIDTH: the time-domain sample.
REQ-007 SHALL have in_valid, input, 1, and in_ready, output, 1: the input handshake.
REQ-008 SHALL have fft_samples, output, [SAMPLES-1:0] of WIDTH: the frame driven to the FFT datapath.
REQ-009 SHALL have fft_start, output, 1: a one-cycle pulse that launches the datapath.
REQ-010 SHALL have fft_result, input, [SAMPLES-1:0] of WIDTH: the bins returned by the datapath.
REQ-011 SHALL have out_data, output, WIDTH; out_index, output, $clog2(SAMPLES); out_last, output, 1: one bin, its index, and end of frame.
REQ-012 SHALL have out_valid, output, 1, and out_ready, input, 1: the output handshake.
REQ-013 SHALL have busy, output, 1: high whenever the state is not FILL.

Function
REQ-014 SHALL have exactly three states: FILL, COMPUTE and DRAIN.
REQ-015 SHALL, in FILL, hold in_ready=1 and out_valid=0; each in_valid&&in_ready beat writes in_data to sample_buf[wr_idx] and increments wr_idx.
REQ-016 SHALL, on the beat where wr_idx==SAMPLES-1, go to COMPUTE on the next edge, assert fft_start for exactly that first COMPUTE cycle, load wait_cnt=COMPUTE_CYCLES and clear wr_idx.
REQ-017 SHALL, in COMPUTE, hold in_ready=0 and decrement wait_cnt each cycle.
REQ-018 SHALL, when wait_cnt reaches 1, capture all of fft_result into result_buf on that edge and go to DRAIN.
REQ-019 SHALL drive fft_samples from sample_buf in every state; sample_buf does not change outside FILL.
REQ-020 SHALL, in DRAIN, hold out_valid=1 and in_ready=0, with out_index=order(rd_idx), out_data=result_buf[out_index] and out_last=(rd_idx==SAMPLES-1).
REQ-021 SHALL hold out_data, out_index and out_last stable while out_valid&&!out_ready; rd_idx advances only on a handshake.
REQ-022 SHALL, on the handshake with out_last=1, clear rd_idx and return to FILL; the first new sample is accepted on the following cycle.
REQ-023 SHALL meet this latency: last input accepted at edge T gives out_valid=1 from edge T+COMPUTE_CYCLES+1.
REQ-024 SHALL ignore in_valid outside FILL and ignore out_ready outside DRAIN.

Reset
REQ-025 SHALL, while rst=1 and regardless of clk, force state=FILL, wr_idx=rd_idx=wait_cnt=0, both buffers to all zero, and outputs in_ready=1 after release, fft_start=0, out_valid=0, out_last=0, out_data=0, out_index=0 and busy=0.
REQ-026 SHALL discard any partial frame, pending computation or undrained bins when reset is asserted mid-operation.

Configuration
REQ-027 SHALL define order(i) as the bit-reverse of i over $clog2(SAMPLES) bits when macro FFT_SEQ_BITREV_OUT_EN is defined, so bins leave in bit-reversed order.
REQ-028 SHALL define order(i)=i when FFT_SEQ_BITREV_OUT_EN is undefined, so bins leave in natural order; nothing else changes.

Structure
REQ-029 SHALL place the state enum (FILL/COMPUTE/DRAIN) and a bit_reverse function in package fft_seq_pkg.
REQ-030 SHALL implement the capture and result storage as sub-module fft_seq_result_buf, with a capture enable and an indexed read port.

Verification
REQ-031 SHALL cover: with an identity datapath stub (fft_result=fft_samples), input samples 0,100,...,1500 and out_ready=1 produce out_data 0,100,...,1500 at out_index 0..15, with out_last only on index 15.
REQ-032 SHALL cover: with FFT_SEQ_BITREV_OUT_EN defined and the same stimulus, out_index follows 0,8,4,12,2,...,15 and out_data equals 100*out_index.
REQ-033 SHALL cover: with COMPUTE_CYCLES=4 and the last sample accepted at edge T, fft_start is high in cycle T+1 only, and out_valid rises at T+5.
REQ-034 SHALL cover: out_ready toggled 1,0,0,1,... during DRAIN keeps out_data stable while stalled, and all 16 bins arrive with none lost or duplicated.
REQ-035 SHALL cover: in_valid held high through COMPUTE and DRAIN accepts no samples (in_ready=0), and the next frame begins only after the out_last handshake.
REQ-036 SHALL cover: rst asserted after 7 samples gives busy=0 with state FILL, and a fresh 16-sample frame then outputs only the new values.
